// File: rtl/smoldvi_pixclk_gen.sv
// smoldvi_pixclk_gen: DDR pixel-clock pattern generator that always emits whole periods.
// Define SMOLDVI_PIXCLK_PHASE_ADJ_EN to enable +1-bit phase steps via phase_inc.
module smoldvi_pixclk_gen #(
    parameter int RATIO = 10,
    parameter int HIGH_BITS = RATIO / 2
) (
    input  logic clk_x5,
    input  logic rst_n_x5,
    input  logic en,
    input  logic phase_inc,
    output logic qp_d0,
    output logic qp_d1,
    output logic qn_d0,
    output logic qn_d1,
    output logic running,
    output logic period_start,
    output logic phase_busy
);
    localparam int W = $clog2(RATIO);
    localparam logic [W-1:0] LAST = W'(RATIO - 2);
    localparam logic [W:0] R = (W + 1)'(RATIO);
    localparam logic [W:0] HB = (W + 1)'(HIGH_BITS);

    typedef enum logic [1:0] {STOPPED, RUNNING, STOPPING} state_t;

    state_t state, nxt;
    logic [W-1:0] pos, pos_nxt, ph;
    logic wrap, act, b0, b1;

    function automatic logic bit_at(input logic [W:0] i, input logic [W-1:0] p);
        logic [W:0] s;
        s = i + {1'b0, p};
        s = (s >= R) ? s - R : s;
        return s < HB;
    endfunction

    assign wrap = pos == LAST;
    assign act = state != STOPPED;
    assign b0 = bit_at({1'b0, pos}, ph);
    assign b1 = bit_at({1'b0, pos} + (W + 1)'(1), ph);

    always_comb begin
        nxt = state;
        unique case (state)
            STOPPED:  nxt = en ? RUNNING : STOPPED;
            RUNNING:  nxt = en ? RUNNING : STOPPING;
            STOPPING: nxt = en ? RUNNING : (wrap ? STOPPED : STOPPING);
            default:  nxt = STOPPED;
        endcase
        pos_nxt = (!act || wrap) ? '0 : pos + W'(2);
    end

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            state <= STOPPED;
            pos <= '0;
        end else begin
            state <= nxt;
            pos <= pos_nxt;
        end
    end

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            qp_d0 <= 1'b0;
            qp_d1 <= 1'b0;
            qn_d0 <= 1'b0;
            qn_d1 <= 1'b0;
            running <= 1'b0;
            period_start <= 1'b0;
        end else begin
            qp_d0 <= act & b0;
            qp_d1 <= act & b1;
            qn_d0 <= act & ~b0;
            qn_d1 <= act & ~b1;
            running <= act;
            period_start <= act && pos == '0;
        end
    end

`ifdef SMOLDVI_PIXCLK_PHASE_ADJ_EN
    logic pending;

    // Phase only moves between periods so no runt pulse is ever emitted.
    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            ph <= '0;
            pending <= 1'b0;
        end else if (pending && (!act || wrap)) begin
            ph <= (ph == W'(RATIO - 1)) ? '0 : ph + W'(1);
            pending <= 1'b0;
        end else if (phase_inc) begin
            pending <= 1'b1;
        end
    end

    assign phase_busy = pending;
`else
    logic unused_phase_inc;

    assign ph = '0;
    assign phase_busy = 1'b0;
    assign unused_phase_inc = phase_inc;
`endif
endmodule

// File: tb/tb_smoldvi_pixclk_gen.sv
// tb_smoldvi_pixclk_gen: directed scoreboard bench for smoldvi_pixclk_gen (defaults and RATIO=8).
module tb_smoldvi_pixclk_gen;
    logic clk_x5 = 1'b0;
    logic rst_n_x5 = 1'b0;
    logic en = 1'b0;
    logic phase_inc = 1'b0;
    logic qp_d0, qp_d1, qn_d0, qn_d1, running, period_start, phase_busy;
    logic r_qp_d0, r_qp_d1, r_qn_d0, r_qn_d1, r_running, r_period_start, r_phase_busy;
    logic [6:0] obs, obs8;
    logic [6:0] q[$];
    logic [6:0] q8[$];
    logic [1:0] p_tab [5] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
    logic [1:0] s_tab [5] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b01};
    int tests = 0;
    int fails = 0;

    smoldvi_pixclk_gen dut (
        .clk_x5(clk_x5), .rst_n_x5(rst_n_x5), .en(en), .phase_inc(phase_inc),
        .qp_d0(qp_d0), .qp_d1(qp_d1), .qn_d0(qn_d0), .qn_d1(qn_d1),
        .running(running), .period_start(period_start), .phase_busy(phase_busy)
    );

    smoldvi_pixclk_gen #(.RATIO(8), .HIGH_BITS(2)) dut8 (
        .clk_x5(clk_x5), .rst_n_x5(rst_n_x5), .en(en), .phase_inc(1'b0),
        .qp_d0(r_qp_d0), .qp_d1(r_qp_d1), .qn_d0(r_qn_d0), .qn_d1(r_qn_d1),
        .running(r_running), .period_start(r_period_start), .phase_busy(r_phase_busy)
    );

    assign obs = {qp_d0, qp_d1, qn_d0, qn_d1, running, period_start, phase_busy};
    assign obs8 = {r_qp_d0, r_qp_d1, r_qn_d0, r_qn_d1, r_running, r_period_start, r_phase_busy};

    always #5 clk_x5 = ~clk_x5;

    function automatic logic [6:0] mk(input logic [1:0] qp, input logic run, input logic ps,
                                      input logic busy);
        return {qp, run ? ~qp : 2'b00, run, ps, busy};
    endfunction

    task automatic cmp(input string tag, input logic [6:0] o, input logic [6:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic pop_cmp(input string tag);
        logic [6:0] e;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = q.pop_front();
            cmp(tag, obs, e);
        end
        if (q8.size() != 0) begin
            e = q8.pop_front();
            cmp({tag, "_r8"}, obs8, e);
        end
    endtask

    task automatic cyc(input string tag, input logic e, input logic [1:0] qp, input logic run,
                       input logic ps, input logic busy);
        en = e;
        q.push_back(mk(qp, run, ps, busy));
        @(posedge clk_x5);
        #1;
        pop_cmp(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        en = 1'b1;
        #3;
        q.push_back('0);
        q8.push_back('0);
        pop_cmp("reset_async");
        repeat (2) begin
            q8.push_back('0);
            cyc("in_reset", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        rst_n_x5 = 1'b1;
        q8.push_back('0);
        cyc("start_latency", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 10; n++) begin
            q8.push_back(mk((n % 4 == 0) ? 2'b11 : 2'b00, 1'b1, n % 4 == 0, 1'b0));
            cyc("run", 1'b1, p_tab[n % 5], 1'b1, n % 5 == 0, 1'b0);
        end
        // drop en at pos=4: the period drains, then stops
        cyc("run", 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
        cyc("run", 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        cyc("drain", 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc("drain", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc("drain", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc("stopped", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc("stopped", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        // en bounced inside STOPPING, including a re-raise on the wrap cycle
        cyc("restart", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc("bounce", 1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
        cyc("bounce", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        cyc("bounce", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc("bounce", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc("bounce", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc("bounce", 1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
        cyc("bounce", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        cyc("bounce", 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc("bounce", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc("wrap_reraise", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc("wrap_reraise", 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
`ifdef SMOLDVI_PIXCLK_PHASE_ADJ_EN
        phase_inc = 1'b1;
        cyc("ph_req", 1'b1, 2'b11, 1'b1, 1'b0, 1'b1);
        phase_inc = 1'b0;
        cyc("ph_busy", 1'b1, 2'b10, 1'b1, 1'b0, 1'b1);
        phase_inc = 1'b1;
        cyc("ph_busy", 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        phase_inc = 1'b0;
        cyc("ph_apply", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 10; n++)
            cyc("ph_shift", 1'b1, s_tab[n % 5], 1'b1, n % 5 == 0, 1'b0);
`else
        phase_inc = 1'b1;
        cyc("ph_ignored", 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        phase_inc = 1'b0;
        cyc("ph_ignored", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc("ph_ignored", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc("ph_ignored", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++)
            cyc("ph_ignored", 1'b1, p_tab[n], 1'b1, n == 0, 1'b0);
`endif
        // asynchronous reset in mid-period, then restart from bit 0 with ph cleared
        cyc("pre_rst", 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n_x5 = 1'b0;
        #1;
        q.push_back('0);
        pop_cmp("rst_async_mid");
        cyc("rst_hold", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n_x5 = 1'b1;
        cyc("rst_latency", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++)
            cyc("after_rst", 1'b1, p_tab[n], 1'b1, n == 0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/smoldvi_pixclk_gen.md
SMOLDVI_PIXCLK_GEN -- requirements
Module: smoldvi_pixclk_gen

Interface
REQ-001 The block SHALL have parameter RATIO, default 10, meaning bit-clock half-periods per pixel period (even, 4..32).
REQ-002 The block SHALL have parameter HIGH_BITS, default RATIO/2, meaning bits high per pixel period (1..RATIO-1).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports as below.
- clk_x5  input  1  half-rate bit clock; all logic on its rising edge.
- rst_n_x5  input  1  asynchronous active-low reset.
- en  input  1  request to run the pixel clock.
- phase_inc  input  1  one-cycle pulse requesting a +1-bit phase shift (macro-dependent).
- qp_d0, qp_d1  output  1 each  DDR bit pair for the positive leg; d0 goes out first.
- qn_d0, qn_d1  output  1 each  DDR bit pair for the negative leg.
- running  output  1  high while the pattern is being driven.
- period_start  output  1  pulse on the cycle whose pair carries bit 0 of a period.
- phase_busy  output  1  high while a phase request is pending.

Function
REQ-004 pos SHALL be a $clog2(RATIO)-bit counter that steps by 2 per cycle and wraps from RATIO-2 to 0, so one period lasts RATIO/2 cycles.
REQ-005 Pattern bit b(i) SHALL be 1 for ((i+ph) mod RATIO) < HIGH_BITS, and 0 otherwise; ph is the phase register (0 when the macro is absent).
REQ-006 All outputs SHALL be registered, so outputs lag state by 1 cycle.
REQ-007 In RUNNING/STOPPING, the outputs SHALL be qp_d0=b(pos), qp_d1=b(pos+1), qn_d0=~qp_d0 and qn_d1=~qp_d1.
REQ-008 The FSM SHALL have the states STOPPED, RUNNING and STOPPING; the encoding is free.
REQ-009 In STOPPED, pos SHALL be held at 0, all four q outputs SHALL be 0, and running and period_start SHALL be 0.
REQ-010 In STOPPED with en=1, the FSM SHALL go to RUNNING next cycle, and the first output pair SHALL be bit 0 with period_start=1.
REQ-011 In RUNNING with en=0, the FSM SHALL go to STOPPING, and the pattern SHALL continue unbroken.
REQ-012 STOPPING SHALL go to STOPPED on the cycle pos wraps to 0, so no period is truncated.
REQ-013 STOPPING with en=1 SHALL return to RUNNING with no break in the pattern.
REQ-014 running SHALL be 1 in RUNNING and STOPPING, and 0 in STOPPED.
REQ-015 period_start SHALL be 1 exactly when the emitted pair has pos=0.
REQ-016 Pattern correctness SHALL not depend on en toggling; any en sequence SHALL yield only whole periods.

Reset
REQ-017 Reset SHALL force state=STOPPED, pos=0, ph=0 and pending=0.
REQ-018 During reset, all outputs SHALL be 0.
REQ-019 Reset asserted mid-period SHALL zero the outputs immediately (asynchronous); a partial period is accepted.
REQ-020 After reset release, the first output change SHALL occur no earlier than 2 edges after en=1.

Configuration
REQ-021 The macro SMOLDVI_PIXCLK_PHASE_ADJ_EN SHALL control phase adjustment.
REQ-022 With SMOLDVI_PIXCLK_PHASE_ADJ_EN defined, a phase_inc pulse SHALL set pending and phase_busy.
REQ-023 With the macro defined, at the next pos wrap to 0 while running, ph SHALL become (ph+1) mod RATIO and pending SHALL clear.
REQ-024 With the macro defined, a phase change SHALL take effect only at a period boundary, so the affected period is RATIO-1 bits long with no runt pulse.
REQ-025 With the macro defined, phase_inc arriving while pending is set SHALL be ignored (no queueing).
REQ-026 With the macro defined, in STOPPED, a request SHALL apply on the next cycle.
REQ-027 Without SMOLDVI_PIXCLK_PHASE_ADJ_EN, phase_inc SHALL be ignored, ph SHALL be the constant 0, phase_busy SHALL be tied 0, and no ph/pending flops SHALL exist.

Verification
REQ-028 Defaults with en=1 from reset SHALL repeat qp pairs 11,11,10,00,00, with qn as the complement and period_start every 5th cycle.
REQ-029 RATIO=8 with HIGH_BITS=2 SHALL repeat qp pairs 11,00,00,00.
REQ-030 en dropped at pos=4 (defaults) SHALL give pairs 00,00, then STOPPED with outputs 0 and running falling after the period completes.
REQ-031 en dropped then re-raised within STOPPING SHALL produce an unbroken 11,11,10,00,00 stream, with running held at 1.
REQ-032 With the macro defined, phase_inc mid-period SHALL keep phase_busy=1 until the boundary; the next periods SHALL be 11,11,00,00,01 then 11,11,00,00,01, with a second phase_inc while busy ignored.
REQ-033 rst_n_x5 pulsed low mid-period SHALL zero outputs asynchronously; after release with en=1, the stream SHALL restart at bit 0.
